// File: rtl/fir_stream_checker_pkg.sv
// Shared definitions for the FIR output stream checker.
//   state_t      : checker run state (idle, running, finished ok, finished by timeout)
//   *_DEF        : default parameter values used by the top level
//   state_done() : true in either terminal state
package fir_stream_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE_OK = 2'd2,
    ST_DONE_TO = 2'd3
  } state_t;

  localparam int NB_DEF       = 8;
  localparam int DEPTH_DEF    = 16;
  localparam int NSAMPLES_DEF = 64;
  localparam int TOL_DEF      = 1;
  localparam int TIMEOUT_DEF  = 256;
  localparam int CW_DEF       = 16;

  function automatic logic state_done(input state_t s);
    return (s == ST_DONE_OK) || (s == ST_DONE_TO);
  endfunction

endpackage

// File: rtl/fir_stream_checker_fifo.sv
// Expected-sample FIFO for the stream checker.
//   CLK, RST : clock, synchronous active-high reset (empties the FIFO)
//   push/din : write request and data (ignored while full)
//   pop      : read request (ignored while empty), head is the current front entry
//   full/empty : registered occupancy flags
// Pointers carry one extra bit so full and empty are distinguishable when the
// index bits match.
module fir_stream_checker_fifo #(
  parameter int NB    = 8,
  parameter int DEPTH = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic [NB-1:0] din,
  input  logic          pop,
  output logic [NB-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [NB-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, wr_next, rd_next;
  logic          do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign wr_next = do_push ? wr_ptr + (AW+1)'(1) : wr_ptr;
  assign rd_next = do_pop  ? rd_ptr + (AW+1)'(1) : rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      full   <= (wr_next[AW] != rd_next[AW]) && (wr_next[AW-1:0] == rd_next[AW-1:0]);
      empty  <= (wr_next == rd_next);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fir_stream_checker.sv
// Self-checking receive end of the FIR output stream.
//   CLK, RST          : clock, synchronous active-high reset
//   START             : pulse, begins a run from IDLE
//   VIN, DIN          : FIR output valid / sample (two's complement)
//   EXP_VALID/EXP_DIN : golden sample push; EXP_READY = FIFO not full
//   DONE, PASS        : run finished; verdict (meaningful only with DONE)
//   TIMED_OUT, UNDERFLOW, OVERFLOW : sticky fault flags
//   ERR_CNT, SAMPLE_CNT, FIRST_ERR : failed compares, compares done,
//                                    index of first failure (all-ones if none)
// Each VIN in RUN pops the golden head and compares within +/-TOL. A VIN with
// no golden data is a failed compare that pops nothing.
module fir_stream_checker
  import fir_stream_checker_pkg::*;
#(
  parameter int NB       = NB_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NSAMPLES = NSAMPLES_DEF,
  parameter int TOL      = TOL_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          VIN,
  input  logic [NB-1:0] DIN,
  input  logic          EXP_VALID,
  input  logic [NB-1:0] EXP_DIN,
  output logic          EXP_READY,
  output logic          DONE,
  output logic          PASS,
  output logic          TIMED_OUT,
  output logic          UNDERFLOW,
  output logic          OVERFLOW,
  output logic [CW-1:0] ERR_CNT,
  output logic [CW-1:0] SAMPLE_CNT,
  output logic [CW-1:0] FIRST_ERR
);

  localparam logic signed [NB:0] TOL_P = (NB+1)'(TOL);
  localparam logic signed [NB:0] TOL_N = -TOL_P;

  state_t            state, state_next;
  logic              full, empty, push, cmp, pop, fail;
  logic [NB-1:0]     head;
  logic signed [NB:0] diff;
  logic [CW-1:0]     sample_cnt, err_cnt, first_err, idle_cnt;
  logic              timed_out, underflow, overflow;

  // A full FIFO refuses the push even if a pop happens the same cycle.
  assign push = EXP_VALID && !full;
  assign cmp  = (state == ST_RUN) && VIN;
  assign pop  = cmp && !empty;

  fir_stream_checker_fifo #(.NB(NB), .DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .din   (EXP_DIN),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // One extra bit keeps e.g. 0x7F - 0x80 = +255 from wrapping into range.
  assign diff = {DIN[NB-1], DIN} - {head[NB-1], head};
  assign fail = empty || (diff > TOL_P) || (diff < TOL_N);

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (START) state_next = ST_RUN;
      ST_RUN: begin
        if (VIN && sample_cnt == CW'(NSAMPLES-1))
          state_next = ST_DONE_OK;
        else if (!VIN && idle_cnt == CW'(TIMEOUT-1))
          state_next = ST_DONE_TO;
      end
      ST_DONE_OK: state_next = ST_DONE_OK;
      ST_DONE_TO: state_next = ST_DONE_TO;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      first_err  <= '1;
      idle_cnt   <= '0;
      timed_out  <= 1'b0;
      underflow  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (cmp) begin
        if (sample_cnt != '1) sample_cnt <= sample_cnt + CW'(1);
        if (fail) begin
          if (err_cnt != '1)   err_cnt   <= err_cnt + CW'(1);
          if (first_err == '1) first_err <= sample_cnt;
        end
        if (empty) underflow <= 1'b1;
      end
      if (EXP_VALID && full) overflow <= 1'b1;
      // Held at zero in IDLE so a run always starts with a fresh idle window.
      if (state != ST_RUN || VIN) idle_cnt <= '0;
      else if (idle_cnt != '1)    idle_cnt <= idle_cnt + CW'(1);
      if (state == ST_RUN && state_next == ST_DONE_TO) timed_out <= 1'b1;
    end
  end

  assign EXP_READY  = !full;
  assign DONE       = state_done(state);
  assign PASS       = (state == ST_DONE_OK) && (err_cnt == '0) && !underflow && !overflow;
  assign TIMED_OUT  = timed_out;
  assign UNDERFLOW  = underflow;
  assign OVERFLOW   = overflow;
  assign ERR_CNT    = err_cnt;
  assign SAMPLE_CNT = sample_cnt;
  assign FIRST_ERR  = first_err;

endmodule

// File: tb/tb_fir_stream_checker.sv
// Bench for fir_stream_checker: a queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_fir_stream_checker;

  localparam int NB = 8, DEPTH = 16, NSAMPLES = 64, TOL = 1, TIMEOUT = 256, CW = 16;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, vin = 1'b0, exp_valid = 1'b0;
  logic [NB-1:0] din = '0, exp_din = '0;
  logic          exp_ready, done, pass, timed_out, underflow, overflow;
  logic [CW-1:0] err_cnt, sample_cnt, first_err;

  always #5 clk = ~clk;

  fir_stream_checker #(
    .NB(NB), .DEPTH(DEPTH), .NSAMPLES(NSAMPLES), .TOL(TOL), .TIMEOUT(TIMEOUT), .CW(CW)
  ) dut (
    .CLK(clk), .RST(rst), .START(start), .VIN(vin), .DIN(din),
    .EXP_VALID(exp_valid), .EXP_DIN(exp_din), .EXP_READY(exp_ready),
    .DONE(done), .PASS(pass), .TIMED_OUT(timed_out), .UNDERFLOW(underflow),
    .OVERFLOW(overflow), .ERR_CNT(err_cnt), .SAMPLE_CNT(sample_cnt), .FIRST_ERR(first_err)
  );

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Reference model: golden queue plus run bookkeeping.
  // m_mode: 0 waiting for start, 1 running, 2 finished by count, 3 finished by timeout
  logic [NB-1:0] mq[$];
  logic [NB-1:0] m_head;
  int  m_mode, m_samples, m_err, m_first, m_idle, m_diff;
  bit  m_under, m_over, m_to, m_was_full, m_was_empty, m_fail;
  bit  chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_mode = 0; m_samples = 0; m_err = 0; m_first = 32'hFFFF; m_idle = 0;
      m_under = 0; m_over = 0; m_to = 0;
      chk_en = 1'b1;
    end else begin
      m_was_full  = (mq.size() == DEPTH);
      m_was_empty = (mq.size() == 0);
      if (m_mode == 1) begin
        if (vin) begin
          m_idle = 0;
          if (m_was_empty) begin
            m_fail  = 1;
            m_under = 1;
          end else begin
            m_head = mq.pop_front();
            m_diff = int'($signed(din)) - int'($signed(m_head));
            m_fail = (m_diff > TOL) || (m_diff < -TOL);
          end
          if (m_fail) begin
            m_err++;
            if (m_first == 32'hFFFF) m_first = m_samples;
          end
          m_samples++;
          if (m_samples == NSAMPLES) m_mode = 2;
        end else begin
          m_idle++;
          if (m_idle == TIMEOUT) begin
            m_mode = 3;
            m_to   = 1;
          end
        end
      end else if (m_mode == 0 && start) begin
        m_mode = 1;
        m_idle = 0;
      end
      if (exp_valid) begin
        if (m_was_full) m_over = 1;
        else            mq.push_back(exp_din);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("exp_ready",  exp_ready,  32'(mq.size() < DEPTH));
      check("done",       done,       32'(m_mode >= 2));
      check("pass",       pass,       32'(m_mode == 2 && m_err == 0 && !m_under && !m_over));
      check("timed_out",  timed_out,  32'(m_to));
      check("underflow",  underflow,  32'(m_under));
      check("overflow",   overflow,   32'(m_over));
      check("err_cnt",    err_cnt,    m_err);
      check("sample_cnt", sample_cnt, m_samples);
      check("first_err",  first_err,  m_first);
    end
  end

  // Stimulus helpers: each is entered on a negedge and returns on a negedge.
  task automatic do_reset();
    rst = 1'b1; @(negedge clk); rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic drive_push(input logic [NB-1:0] v);
    exp_valid = 1'b1; exp_din = v; @(negedge clk); exp_valid = 1'b0;
  endtask

  task automatic drive_vin(input logic [NB-1:0] d);
    vin = 1'b1; din = d; @(negedge clk); vin = 1'b0;
  endtask

  function automatic logic [NB-1:0] gold(input int i);
    return (i == 10) ? 8'h7F : 8'(i * 3);
  endfunction

  // mode 0: exact match; mode 1: +1 everywhere, -2 at sample 10
  function automatic logic [NB-1:0] dval(input int i, input int mode);
    if (mode == 0) return gold(i);
    if (i == 10)   return 8'h7D;
    return gold(i) + 8'd1;
  endfunction

  // Preload 16, START, then one VIN every 3 cycles with a refill push in between.
  // abort_at >= 0 pulses RST instead of sending that sample.
  task automatic run_stream(input int mode, input int abort_at);
    for (int i = 0; i < DEPTH; i++) drive_push(gold(i));
    pulse_start();
    for (int i = 0; i < NSAMPLES; i++) begin
      if (i == abort_at) begin
        do_reset();
        return;
      end
      drive_vin(dval(i, mode));
      if (i + DEPTH < NSAMPLES) drive_push(gold(i + DEPTH));
      else @(negedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int  n_lat;
  bit  seen;

  initial begin
    @(negedge clk);
    do_reset();
    check("rst_exp_ready", exp_ready, 1);
    check("rst_done", done, 0);
    check("rst_first_err", first_err, 32'hFFFF);
    check("rst_err_cnt", err_cnt, 0);

    // 1: clean run
    run_stream(0, -1);
    check("t1_done", done, 1);
    check("t1_pass", pass, 1);
    check("t1_err_cnt", err_cnt, 0);
    check("t1_sample_cnt", sample_cnt, 64);
    check("t1_first_err", first_err, 32'hFFFF);

    // 2: within tolerance everywhere except sample 10
    do_reset();
    run_stream(1, -1);
    check("t2_done", done, 1);
    check("t2_err_cnt", err_cnt, 1);
    check("t2_first_err", first_err, 10);
    check("t2_pass", pass, 0);

    // 3: sign-boundary difference must fail; then a +1 difference passes
    do_reset();
    drive_push(8'h80);
    drive_push(8'h03);
    pulse_start();
    drive_vin(8'h7F);
    drive_vin(8'h04);
    @(negedge clk);
    check("t3_err_cnt", err_cnt, 1);
    check("t3_first_err", first_err, 0);
    check("t3_sample_cnt", sample_cnt, 2);

    // 4: overflow then underflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) drive_push(8'(i * 5));
    check("t4_ready_full", exp_ready, 0);
    drive_push(8'hAA);
    check("t4_overflow", overflow, 1);
    pulse_start();
    for (int i = 0; i < DEPTH; i++) drive_vin(8'(i * 5));
    check("t4_err_before", err_cnt, 0);
    drive_vin(8'h00);
    check("t4_underflow", underflow, 1);
    check("t4_err_cnt", err_cnt, 1);
    check("t4_first_err", first_err, 16);
    check("t4_pass", pass, 0);
    check("t4_ready", exp_ready, 1);

    // 5: timeout exactly TIMEOUT cycles after the last VIN
    do_reset();
    for (int i = 0; i < 5; i++) drive_push(8'(i + 1));
    pulse_start();
    for (int i = 0; i < 5; i++) drive_vin(8'(i + 1));
    n_lat = 0;
    seen  = 1'b0;
    for (int c = 0; c < TIMEOUT + 50 && !seen; c++) begin
      @(posedge clk);
      n_lat++;
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("t5_done_seen", 32'(seen), 1);
    check("t5_latency", n_lat, TIMEOUT);
    check("t5_timed_out", timed_out, 1);
    check("t5_pass", pass, 0);
    check("t5_sample_cnt", sample_cnt, 5);

    // 6: reset mid-run, then a clean restart
    do_reset();
    run_stream(0, 30);
    check("t6_rst_done", done, 0);
    check("t6_rst_sample_cnt", sample_cnt, 0);
    check("t6_rst_first_err", first_err, 32'hFFFF);
    check("t6_rst_exp_ready", exp_ready, 1);
    run_stream(0, -1);
    check("t6_pass", pass, 1);
    check("t6_sample_cnt", sample_cnt, 64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
